// File: rtl/lvds_rx_pkg.sv
// Shared types and constants for the 7:1 LVDS receive word aligner.
package lvds_rx_pkg;

  localparam int LVDS_WORD_W = 7;
  localparam logic [LVDS_WORD_W-1:0] CLK_PATTERN_DEF = 7'b1100011;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SLIP   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } rx_state_e;

endpackage

// File: rtl/lvds_sync2.sv
// Two-flop synchroniser bringing a single asynchronous level into the clk domain.
module lvds_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/lvds_7to1_rx_align.sv
// 7:1 LVDS receive word aligner: bitslips the deserializers until the clock lane
// shows the expected pattern, forwards aligned data and supervises the lock.
module lvds_7to1_rx_align
  import lvds_rx_pkg::*;
#(
  parameter int                     NUM_LANES   = 4,
  parameter logic [LVDS_WORD_W-1:0] CLK_PATTERN = CLK_PATTERN_DEF,
  parameter int                     SLIP_WAIT   = 8,
  parameter int                     LOCK_COUNT  = 16,
  parameter int                     LOSS_COUNT  = 4,
  parameter int                     MAX_SLIPS   = 14,
  parameter int                     PLLRST_CYC  = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               pll_lock,
  input  logic [LVDS_WORD_W-1:0]             clk_lane,
  input  logic [NUM_LANES*LVDS_WORD_W-1:0]   data_in,
  output logic                               calib,
  output logic [NUM_LANES*LVDS_WORD_W-1:0]   data_out,
  output logic                               data_valid,
  output logic                               aligned,
  output logic                               align_err,
  output logic                               pll_reset_req,
  output logic [3:0]                         slip_count
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int SLIP_W  = $clog2(MAX_SLIPS + 1);
  localparam int WAIT_W  = $clog2(SLIP_WAIT + 1);
  localparam int LOSS_W  = $clog2(LOSS_COUNT + 1);
  localparam int FAIL_W  = $clog2(PLLRST_CYC + 1);

  rx_state_e            state_r, state_nx_s;
  logic [MATCH_W-1:0]   match_cnt_r, match_cnt_nx_s;
  logic [SLIP_W-1:0]    slip_cnt_r, slip_cnt_nx_s;
  logic [WAIT_W-1:0]    wait_cnt_r, wait_cnt_nx_s;
  logic [LOSS_W-1:0]    loss_cnt_r, loss_cnt_nx_s;
  logic [FAIL_W-1:0]    fail_cnt_r, fail_cnt_nx_s;
  logic                 lock_s, match_s, pulse_s, clr_err_s;
  logic                 calib_r, aligned_r, data_valid_r, align_err_r, pll_reset_req_r;
  logic [NUM_LANES*LVDS_WORD_W-1:0] data_out_r;

  lvds_sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign match_s = (clk_lane == CLK_PATTERN);

  // next-state and counter update; loss of lock outranks every other transition
  always_comb begin
    state_nx_s     = state_r;
    match_cnt_nx_s = match_cnt_r;
    slip_cnt_nx_s  = slip_cnt_r;
    wait_cnt_nx_s  = wait_cnt_r;
    loss_cnt_nx_s  = loss_cnt_r;
    fail_cnt_nx_s  = fail_cnt_r;
    pulse_s        = 1'b0;
    clr_err_s      = 1'b0;
    if (!lock_s && (state_r != ST_FAIL)) begin
      state_nx_s     = ST_IDLE;
      match_cnt_nx_s = '0;
      slip_cnt_nx_s  = '0;
      wait_cnt_nx_s  = '0;
      loss_cnt_nx_s  = '0;
      fail_cnt_nx_s  = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          match_cnt_nx_s = '0;
          slip_cnt_nx_s  = '0;
          state_nx_s     = ST_CHECK;
        end
        ST_CHECK: begin
          if (!match_s) begin
            match_cnt_nx_s = '0;
            state_nx_s     = ST_SLIP;
          end else if (match_cnt_r == MATCH_W'(LOCK_COUNT - 1)) begin
            match_cnt_nx_s = '0;
            loss_cnt_nx_s  = '0;
            clr_err_s      = 1'b1;
            state_nx_s     = ST_LOCKED;
          end else begin
            match_cnt_nx_s = match_cnt_r + MATCH_W'(1);
          end
        end
        ST_SLIP: begin
          if (slip_cnt_r == SLIP_W'(MAX_SLIPS)) begin
            fail_cnt_nx_s = '0;
            state_nx_s    = ST_FAIL;
          end else begin
            pulse_s       = 1'b1;
            slip_cnt_nx_s = slip_cnt_r + SLIP_W'(1);
            wait_cnt_nx_s = '0;
            state_nx_s    = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_r == WAIT_W'(SLIP_WAIT - 1)) begin
            wait_cnt_nx_s = '0;
            state_nx_s    = ST_CHECK;
          end else begin
            wait_cnt_nx_s = wait_cnt_r + WAIT_W'(1);
          end
        end
        ST_LOCKED: begin
          if (match_s) begin
            loss_cnt_nx_s = '0;
          end else if (loss_cnt_r == LOSS_W'(LOSS_COUNT - 1)) begin
            loss_cnt_nx_s  = '0;
            slip_cnt_nx_s  = '0;
            match_cnt_nx_s = '0;
            state_nx_s     = ST_CHECK;
          end else begin
            loss_cnt_nx_s = loss_cnt_r + LOSS_W'(1);
          end
        end
        ST_FAIL: begin
          if (fail_cnt_r == FAIL_W'(PLLRST_CYC - 1)) begin
            fail_cnt_nx_s = '0;
            state_nx_s    = ST_IDLE;
          end else begin
            fail_cnt_nx_s = fail_cnt_r + FAIL_W'(1);
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end
  end

  // state and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      match_cnt_r <= '0;
      slip_cnt_r  <= '0;
      wait_cnt_r  <= '0;
      loss_cnt_r  <= '0;
      fail_cnt_r  <= '0;
    end else begin
      state_r     <= state_nx_s;
      match_cnt_r <= match_cnt_nx_s;
      slip_cnt_r  <= slip_cnt_nx_s;
      wait_cnt_r  <= wait_cnt_nx_s;
      loss_cnt_r  <= loss_cnt_nx_s;
      fail_cnt_r  <= fail_cnt_nx_s;
    end
  end

  // registered outputs; data_valid waits one cycle after LOCKED entry so data_out is fresh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      calib_r         <= 1'b0;
      aligned_r       <= 1'b0;
      data_valid_r    <= 1'b0;
      align_err_r     <= 1'b0;
      pll_reset_req_r <= 1'b0;
      data_out_r      <= '0;
    end else begin
      calib_r         <= pulse_s;
      aligned_r       <= (state_nx_s == ST_LOCKED);
      data_valid_r    <= (state_r == ST_LOCKED) && (state_nx_s == ST_LOCKED);
      pll_reset_req_r <= (state_nx_s == ST_FAIL);
      if (state_nx_s == ST_FAIL) begin
        align_err_r <= 1'b1;
      end else if (clr_err_s) begin
        align_err_r <= 1'b0;
      end
      if (state_r == ST_LOCKED) begin
        data_out_r <= data_in;
      end
    end
  end

  assign calib         = calib_r;
  assign aligned       = aligned_r;
  assign data_valid    = data_valid_r;
  assign align_err     = align_err_r;
  assign pll_reset_req = pll_reset_req_r;
  assign data_out      = data_out_r;
  assign slip_count    = 4'(slip_cnt_r);

endmodule
